// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first two's-complement subtractor.
// Computes diff = a - b - borrow_in over WIDTH cycles with one full-subtractor
// cell and a registered borrow. A start/busy/done handshake sequences it.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d_c;
    logic             bit_bo_c;
    logic             last_c;
    logic             load_c;
    logic [WIDTH-1:0] res_next_c;

    // Full-subtractor cell on the current LSBs plus the running borrow
    always_comb begin
        bit_d_c  = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        bit_bo_c = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
        last_c   = (cnt_q == LAST_CNT);
        load_c   = start && (state_q != ST_RUN);
        res_next_c = {bit_d_c, res_sh_q[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE can accept a new start directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; results change only on entering DONE
    always_comb begin
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        brw_d        = brw_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        zero_d       = zero_q;
        busy_d       = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);

        if (load_c) begin
            a_sh_d   = a;
            b_sh_d   = b;
            res_sh_d = '0;
            brw_d    = borrow_in;
            cnt_d    = '0;
        end else if (state_q == ST_RUN) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_next_c;
            brw_d    = bit_bo_c;
            cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
            if (last_c) begin
                diff_d       = res_next_c;
                borrow_out_d = bit_bo_c;
                zero_d       = (res_next_c == '0);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            brw_q        <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            brw_q        <= brw_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            zero_q       <= zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

endmodule
